// File: rtl/control_fsm_main.sv
// rtl/control_fsm_main.sv - multicycle RV32I main controller FSM
// Optional EXT_BRANCH_EN adds BLT/BGE/BLTU/BGEU; without it those funct3 values trap.
module control_fsm_main #(
  parameter int STATE_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero_flag,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       output_en,
  output logic [2:0] out_mux_sel,
  output logic [2:0] imm_sel,
  output logic [2:0] alu_src_a_sel,
  output logic [2:0] alu_src_b_sel,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR_ADR, S_JUMP,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  state_t state_q, state_d;

  logic pc_write_c, ir_write_c, mem_write_c, reg_write_c, output_en_c;

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    adr_src       = 1'b0;
    pc_write_c    = 1'b0;
    ir_write_c    = 1'b0;
    mem_write_c   = 1'b0;
    reg_write_c   = 1'b0;
    output_en_c   = 1'b1;
    out_mux_sel   = 3'd0;
    imm_sel       = IMM_I;
    alu_src_a_sel = 3'd0;
    alu_src_b_sel = 3'd0;
    alu_ctrl      = ALU_ADD;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c    = 1'b1;
        pc_write_c    = 1'b1;
        alu_src_a_sel = 3'd1;
        alu_src_b_sel = 3'd2;
        out_mux_sel   = 3'd1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch/jump target lands in alu_reg for later use.
        alu_src_b_sel = 3'd1;
        imm_sel       = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JUMP;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a_sel = 3'd2;
        alu_src_b_sel = 3'd1;
        imm_sel       = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        state_d       = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        out_mux_sel = 3'd2;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_sel = 3'd2;
        alu_ctrl      = alu_decode(funct3, funct7[5]);
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_sel = 3'd2;
        alu_src_b_sel = 3'd1;
        alu_ctrl      = alu_decode(funct3, funct7[5] && (funct3 == 3'b101));
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_sel = 3'd2;
        alu_ctrl      = ALU_SUB;
        state_d       = S_FETCH;
        case (funct3)
          3'b000: pc_write_c = zero_flag;
          3'b001: pc_write_c = !zero_flag;
`ifdef EXT_BRANCH_EN
          3'b100: begin alu_ctrl = ALU_SLT;  pc_write_c = !zero_flag; end
          3'b101: begin alu_ctrl = ALU_SLT;  pc_write_c = zero_flag;  end
          3'b110: begin alu_ctrl = ALU_SLTU; pc_write_c = !zero_flag; end
          3'b111: begin alu_ctrl = ALU_SLTU; pc_write_c = zero_flag;  end
`endif
          default: state_d = S_TRAP;
        endcase
      end
      S_JALR_ADR: begin
        alu_src_a_sel = 3'd2;
        alu_src_b_sel = 3'd1;
        state_d       = S_JUMP;
      end
      S_JUMP: begin
        pc_write_c    = 1'b1;
        alu_src_b_sel = 3'd2;
        state_d       = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_b_sel = 3'd1;
        imm_sel       = IMM_U;
        alu_ctrl      = ALU_PASS;
        state_d       = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_b_sel = 3'd1;
        imm_sel       = IMM_U;
        state_d       = S_ALU_WB;
      end
      S_TRAP: begin
        output_en_c = 1'b0;
        illegal     = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Reset masks every write strobe so an abandoned instruction leaves no side effects.
  assign pc_write  = pc_write_c  & rst;
  assign ir_write  = ir_write_c  & rst;
  assign mem_write = mem_write_c & rst;
  assign reg_write = reg_write_c & rst;
  assign output_en = output_en_c & rst;

endmodule
